// File: rtl/mips_cpu_multdiv.sv
// ---------------------------------------------------------------------------
// mips_cpu_multdiv
//
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// The unit takes 32 cycles of shift-add (multiply) or restoring division,
// then spends one cycle on the sign fix-up. Start-to-start latency is 34
// cycles.
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset (HI/LO <- HILO_RESET, FSM idle)
//   start    begin an operation; honoured only while busy=0
//   op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   op_a     operand A (rs)
//   op_b     operand B (rt)
//   mthi     write wr_data into HI (honoured only while busy=0)
//   mtlo     write wr_data into LO (honoured only while busy=0)
//   wr_data  MTHI/MTLO data
//   busy     operation in progress
//   done     one-cycle pulse once HI/LO hold the new result
//   hi, lo   architectural HI/LO registers
// ---------------------------------------------------------------------------
module mips_cpu_multdiv #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] HILO_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    // Control state (reset)
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // Datapath state (captured at start, no reset needed)
    logic               is_div_q;
    logic               sign_a_q, sign_b_q;
    logic               bzero_q;
    logic [WIDTH-1:0]   a_q, b_q, araw_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic accept;
    logic is_signed;

    assign accept    = (state_q == S_IDLE) && start;
    assign is_signed = ~op[0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            hi_q    <= HILO_RESET;
            lo_q    <= HILO_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_CALC;
            S_CALC:   if (cnt_q == CNT_LAST) state_d = S_FINISH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (state_q == S_CALC) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    // Bits of the multiplier / dividend are consumed MSB first; ~cnt_q
    // equals WIDTH-1-cnt_q for a power-of-two WIDTH.
    logic [CNT_W-1:0]   bit_idx;
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   div_quo;
    logic [2*WIDTH-1:0] mul_step;

    always_comb begin
        bit_idx  = ~cnt_q;
        // Restoring division: acc holds {remainder, quotient}
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], a_q[bit_idx]};
        rem_ge   = rem_sh >= {1'b0, b_q};
        div_rem  = rem_ge ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
        div_quo  = {acc_q[WIDTH-2:0], rem_ge};
        // Shift-add multiply, MSB-first: acc = 2*acc + bit*a
        mul_step = {acc_q[2*WIDTH-2:0], 1'b0}
                 + (b_q[bit_idx] ? {{WIDTH{1'b0}}, a_q} : {(2*WIDTH){1'b0}});
    end

    always_comb begin
        acc_d = acc_q;
        if (accept) begin
            acc_d = '0;
        end else if (state_q == S_CALC) begin
            acc_d = is_div_q ? {div_rem, div_quo} : mul_step;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            is_div_q <= op[1];
            sign_a_q <= is_signed & op_a[WIDTH-1];
            sign_b_q <= is_signed & op_b[WIDTH-1];
            a_q      <= (is_signed & op_a[WIDTH-1]) ? -op_a : op_a;
            b_q      <= (is_signed & op_b[WIDTH-1]) ? -op_b : op_b;
            araw_q   <= op_a;
            bzero_q  <= (op_b == '0);
        end
        acc_q <= acc_d;
    end

    // ------------------------------------------------------------------
    // Sign fix-up and HI/LO update
    // ------------------------------------------------------------------
    // Sign flags are only set for signed ops, so unsigned ops pass through.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quo_fix  = acc_q[WIDTH-1:0];
        rem_fix  = acc_q[2*WIDTH-1:WIDTH];
        if (sign_a_q ^ sign_b_q) quo_fix = -quo_fix;
        if (sign_a_q)            rem_fix = -rem_fix;
        // Divide by zero: all-ones quotient, dividend returned untouched
        if (bzero_q) begin
            quo_fix = '1;
            rem_fix = araw_q;
        end
    end

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        done_d = 1'b0;
        case (state_q)
            S_FINISH: begin
                done_d = 1'b1;
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            S_IDLE: begin
                if (mthi) hi_d = wr_data;
                if (mtlo) lo_d = wr_data;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q != S_IDLE);
        done = done_q;
        hi   = hi_q;
        lo   = lo_q;
    end

endmodule

// File: tb/tb_mips_cpu_multdiv.sv
module tb_mips_cpu_multdiv;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] op_a = 32'h0;
    logic [31:0] op_b = 32'h0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wr_data = 32'h0;
    logic        busy, done;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    mips_cpu_multdiv #(.WIDTH(32), .HILO_RESET(32'h0)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .op_a(op_a), .op_b(op_b), .mthi(mthi), .mtlo(mtlo),
        .wr_data(wr_data), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    // Architectural result of one operation, from plain arithmetic.
    function automatic void ref_result(input logic [1:0] o, input logic [31:0] a,
                                       input logic [31:0] b,
                                       output logic [31:0] rh, output logic [31:0] rl);
        longint          p;
        longint unsigned up;
        int              sa, sb;
        rh = 32'h0; rl = 32'h0;
        case (o)
            2'b00: begin
                p  = longint'($signed(a)) * longint'($signed(b));
                rh = p[63:32]; rl = p[31:0];
            end
            2'b01: begin
                up = {32'h0, a} * {32'h0, b};
                rh = up[63:32]; rl = up[31:0];
            end
            2'b10: begin
                if (b == 32'h0) begin
                    rl = 32'hFFFFFFFF; rh = a;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    rl = 32'h80000000; rh = 32'h0;
                end else begin
                    sa = $signed(a); sb = $signed(b);
                    rl = sa / sb; rh = sa % sb;
                end
            end
            default: begin
                if (b == 32'h0) begin
                    rl = 32'hFFFFFFFF; rh = a;
                end else begin
                    rl = a / b; rh = a % b;
                end
            end
        endcase
    endfunction

    // Behavioural model: 33 busy cycles after an accepted start, then HI/LO update.
    logic [31:0] m_hi = 32'h0, m_lo = 32'h0, r_hi = 32'h0, r_lo = 32'h0;
    int          m_cnt = 0;
    logic        m_done = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi = 32'h0; m_lo = 32'h0; m_cnt = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_hi = r_hi; m_lo = r_lo; m_done = 1'b1;
                end
            end else begin
                if (mthi) m_hi = wr_data;
                if (mtlo) m_lo = wr_data;
                if (start) begin
                    ref_result(op, op_a, op_b, r_hi, r_lo);
                    m_cnt = 33;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            check("busy", {31'h0, busy}, {31'h0, (m_cnt > 0)});
            check("done", {31'h0, done}, {31'h0, m_done});
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
        end
    end

    // Called right after a negedge; issues one op and returns on the first
    // negedge with busy low (the next start can be driven right away).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, output int bcyc);
        start = 1'b1; op = o; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op_a = $urandom; op_b = $urandom;
        bcyc = 0;
        while (busy && bcyc < 40) begin
            bcyc++;
            if (disturb && bcyc == 10) begin
                start = 1'b1; op = 2'b10; op_a = 32'd99; op_b = 32'd1;
                mthi = 1'b1; mtlo = 1'b1; wr_data = 32'hDEAD;
            end else begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        if (bcyc >= 40) check("busy_timeout", 32'(bcyc), 32'd33);
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bc;
        logic [1:0] o;
        logic [31:0] a, b;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        check("init_hi", hi, 32'h0);
        check("init_lo", lo, 32'h0);
        check("init_busy", {31'h0, busy}, 32'h0);

        run_op(2'b00, 32'hFFFFFFFE, 32'd3, 1'b0, bc);
        check("mult_busy_cycles", 32'(bc), 32'd33);
        check("mult_done", {31'h0, done}, 32'h1);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);

        run_op(2'b01, 32'hFFFFFFFE, 32'd3, 1'b0, bc);
        check("multu_hi", hi, 32'h00000002);
        check("multu_lo", lo, 32'hFFFFFFFA);

        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, bc);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        run_op(2'b11, 32'd100, 32'd7, 1'b0, bc);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);

        run_op(2'b11, 32'd5, 32'd0, 1'b0, bc);
        check("divu0_busy_cycles", 32'(bc), 32'd33);
        check("divu0_lo", lo, 32'hFFFFFFFF);
        check("divu0_hi", hi, 32'd5);

        run_op(2'b10, 32'hFFFFFFFB, 32'd0, 1'b0, bc);
        check("div0_lo", lo, 32'hFFFFFFFF);
        check("div0_hi", hi, 32'hFFFFFFFB);

        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, bc);
        check("divovf_lo", lo, 32'h80000000);
        check("divovf_hi", hi, 32'h0);

        @(negedge clk);
        mthi = 1'b1; wr_data = 32'h1234;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_hi", hi, 32'h1234);

        run_op(2'b01, 32'd3, 32'd4, 1'b1, bc);
        check("disturb_busy_cycles", 32'(bc), 32'd33);
        check("disturb_hi", hi, 32'h0);
        check("disturb_lo", lo, 32'd12);
        @(negedge clk);
        check("disturb_no_restart", {31'h0, busy}, 32'h0);

        start = 1'b1; op = 2'b11; op_a = 32'd1000; op_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        async_reset();

        run_op(2'b01, 32'd2, 32'd2, 1'b0, bc);
        check("post_rst_lo", lo, 32'd4);
        check("post_rst_hi", hi, 32'h0);

        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) begin
                mthi = 1'($urandom); mtlo = 1'($urandom); wr_data = $urandom;
                @(negedge clk);
            end
            mthi = 1'($urandom_range(0, 3) == 0);
            mtlo = 1'($urandom_range(0, 3) == 0);
            wr_data = $urandom;
            o = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            run_op(o, a, b, 1'($urandom_range(0, 3) == 0), bc);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mips_cpu_multdiv.md
Name: mips_cpu_multdiv

Overview:
- Iterative multiply/divide unit holding the architectural HI/LO registers.
- Sits directly downstream of the register file: consumes the two read-port operands (rs into op_a, rt into op_b) for MULT/MULTU/DIV/DIVU.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.
- Exposes busy so the control FSM can stall HI/LO-dependent instructions.

Parameters:
- WIDTH, 32, operand/HI/LO width; only 32 is supported, other values are illegal.
- HILO_RESET, 32'h0, value loaded into both HI and LO on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin operation; sampled on a rising edge only when busy=0.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- op_a  input  32  operand A (register file read port A, rs).
- op_b  input  32  operand B (register file read port B, rt).
- mthi  input  1  write wr_data into HI.
- mtlo  input  1  write wr_data into LO.
- wr_data  input  32  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO hold the new result.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (asynchronous, active-high):
  - Takes effect immediately, independent of clk.
  - hi=lo=HILO_RESET, busy=0, done=0, FSM=IDLE, iteration counter=0.
  - Reset mid-operation aborts it; no partial result ever reaches hi/lo.
- FSM states: IDLE, CALC, FINISH.
- IDLE:
  - On the edge where start=1, latch op, |op_a|, |op_b| (absolute values for signed ops, raw values for unsigned ops) and both sign bits.
  - Clear the 64-bit accumulator and counter, then go to CALC.
- CALC: exactly 32 cycles, one bit per cycle. Leave for FINISH on the edge where counter=31.
  - Multiply: shift-add, unsigned 32x32 giving a 64-bit product.
  - Divide: restoring, unsigned 32-bit quotient and remainder.
- FINISH: one cycle applying sign fix-up, then writes hi/lo, sets done=1 and returns to IDLE.
  - MULT: negate the 64-bit product when the operand signs differ. hi=product[63:32], lo=product[31:0].
  - DIV: quotient negated when signs differ; remainder takes the dividend's sign. lo=quotient, hi=remainder.
  - MULTU/DIVU: no fix-up.
- Timing:
  - start sampled at edge E0; busy=1 from E0 through edge E0+33.
  - hi/lo update at edge E0+33; done=1 for the single cycle following E0+33.
  - A new start is accepted on the edge where busy is first 0 again (back-to-back allowed).
  - Total latency: 34 cycles start-to-start.
- start while busy=1: ignored, with no effect on the current operation.
- hi/lo hold their previous values throughout CALC; the control FSM must stall MFHI/MFLO while busy=1.
- Divide by zero (op_b=0), both DIV and DIVU: lo=32'hFFFFFFFF and hi=op_a as issued. No exception; same 34-cycle latency.
- DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0 (wraps, no trap).
- mthi/mtlo:
  - Honoured only when busy=0; they update on that edge. Ignored while busy=1.
  - If mthi and mtlo are both asserted, both registers get wr_data.
  - If asserted together with start in IDLE, the write lands and the operation still starts; the result later overwrites hi/lo.
- Operands are captured at start; later changes on op_a/op_b have no effect.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> hi=lo=0, busy=0 immediately, without waiting for a clock edge.
- MULT: op_a=32'hFFFFFFFE (-2), op_b=3 -> after 34 cycles hi=32'hFFFFFFFF, lo=32'hFFFFFFFA. busy high exactly 33 cycles; done pulses once.
- MULTU: same operands -> hi=32'h00000002, lo=32'hFFFFFFFA.
- DIV -7/2 (32'hFFFFFFF9, 2) -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- DIVU 100/7 -> lo=14, hi=2.
- DIVU 5/0 -> lo=32'hFFFFFFFF, hi=5.
- Busy interaction:
  - MTHI 32'h1234 while idle -> hi=32'h1234 the next cycle.
  - Start MULTU 3*4; pulse mtlo and a second start during CALC -> both ignored; final hi=0, lo=12.
- Reset at cycle 10 of a DIVU -> hi/lo=0, busy=0.
- A new MULTU 2*2 issued after that reset -> lo=4 after 34 cycles.
